regfile_sb: RTL

- Parametrised general-purpose register file for the MIPS datapath: two read ports, one write port, one scoreboard.
- Reads are synchronous, registered at the clock edge, with write-to-read bypass.
- Register 0 is optionally hardwired to zero.
- A per-register busy scoreboard flags in-flight writes (e.g. loads) so decode can stall on RAW hazards. Sits between decode and the execute/writeback stages.

---
 rtl/regfile_sb_if.sv | 43 ++++
 rtl/regfile_sb.sv | 119 +++++++++++
 2 files changed

// File: rtl/regfile_sb_if.sv
// Register-file bus: decode-side read/scoreboard requests, writeback-side
// writes, and the read data / busy flags returned to decode.
interface regfile_sb_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   // read ports
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr_1;
   logic [ADDR_W-1:0] rd_addr_2;
   logic [DATA_W-1:0] rd_data_1;
   logic [DATA_W-1:0] rd_data_2;

   // write port
   logic              wr_en;
   logic              wr_dst;
   logic [ADDR_W-1:0] wr_addr_rt;
   logic [ADDR_W-1:0] wr_addr_rd;
   logic [DATA_W-1:0] wr_data;

   // scoreboard
   logic              sb_set;
   logic [ADDR_W-1:0] sb_addr;
   logic              busy_1;
   logic              busy_2;
   logic              busy_any;

   // Pipeline side: drives requests, consumes data and busy flags.
   modport master (
      output rd_en, rd_addr_1, rd_addr_2,
      output wr_en, wr_dst, wr_addr_rt, wr_addr_rd, wr_data,
      output sb_set, sb_addr,
      input  rd_data_1, rd_data_2, busy_1, busy_2, busy_any
   );

   // Register-file side.
   modport slave (
      input  rd_en, rd_addr_1, rd_addr_2,
      input  wr_en, wr_dst, wr_addr_rt, wr_addr_rd, wr_data,
      input  sb_set, sb_addr,
      output rd_data_1, rd_data_2, busy_1, busy_2, busy_any
   );
endinterface

// File: rtl/regfile_sb.sv
// MIPS general-purpose register file: two registered read ports with
// write-to-read bypass, one write port with rt/rd destination select,
// optional hardwired zero register, and a per-register busy scoreboard
// used by decode to stall on RAW hazards against in-flight writes.
module regfile_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter bit ZERO_REG = 1'b1
) (
   input logic         clk,
   input logic         reset,
   regfile_sb_if.slave bus
);

   localparam int DEPTH = 2 ** ADDR_W;

   // Effective write destination (rt for I-type, rd for R-type).
   logic [ADDR_W-1:0] waddr;

   // Register storage and its next-state values.
   logic [DATA_W-1:0] mem_reg  [DEPTH];
   logic [DATA_W-1:0] mem_next [DEPTH];

   // Busy scoreboard, one bit per register.
   logic [DEPTH-1:0] busy_reg;
   logic [DEPTH-1:0] busy_next;

   // Read data registers and the values they load on an enabled read.
   logic [DATA_W-1:0] rd_data_1_reg;
   logic [DATA_W-1:0] rd_data_2_reg;
   logic [DATA_W-1:0] rd_data_1_next;
   logic [DATA_W-1:0] rd_data_2_next;

   assign waddr = bus.wr_dst ? bus.wr_addr_rd : bus.wr_addr_rt;

   // Per-register next-state: storage update and scoreboard set/clear.
   // A set and a clear of the same register in one cycle leave it busy,
   // because the newly issued write supersedes the one completing now.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
         if (ZERO_REG && gi == 0) begin : g_zero
            assign mem_next[gi]  = '0;
            assign busy_next[gi] = 1'b0;
         end else begin : g_live
            logic wr_hit;
            logic set_hit;
            assign wr_hit        = bus.wr_en  && (waddr == ADDR_W'(gi));
            assign set_hit       = bus.sb_set && (bus.sb_addr == ADDR_W'(gi));
            assign mem_next[gi]  = wr_hit ? bus.wr_data : mem_reg[gi];
            assign busy_next[gi] = set_hit ? 1'b1 : (wr_hit ? 1'b0 : busy_reg[gi]);
         end
      end
   endgenerate

   // Register storage; cleared as a whole by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_reg[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_reg[i] <= mem_next[i];
         end
      end
   end

   // Scoreboard state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_reg <= '0;
      end else begin
         busy_reg <= busy_next;
      end
   end

   // Port 1 read value: zero register, then same-cycle write bypass, then storage.
   always_comb begin
      rd_data_1_next = mem_reg[bus.rd_addr_1];
      if (bus.wr_en && (waddr == bus.rd_addr_1)) begin
         rd_data_1_next = bus.wr_data;
      end
      if (ZERO_REG && (bus.rd_addr_1 == '0)) begin
         rd_data_1_next = '0;
      end
   end

   // Port 2 read value: zero register, then same-cycle write bypass, then storage.
   always_comb begin
      rd_data_2_next = mem_reg[bus.rd_addr_2];
      if (bus.wr_en && (waddr == bus.rd_addr_2)) begin
         rd_data_2_next = bus.wr_data;
      end
      if (ZERO_REG && (bus.rd_addr_2 == '0)) begin
         rd_data_2_next = '0;
      end
   end

   // Read data registers load on rd_en and hold otherwise.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_data_1_reg <= '0;
         rd_data_2_reg <= '0;
      end else if (bus.rd_en) begin
         rd_data_1_reg <= rd_data_1_next;
         rd_data_2_reg <= rd_data_2_next;
      end
   end

   assign bus.rd_data_1 = rd_data_1_reg;
   assign bus.rd_data_2 = rd_data_2_reg;

   // Busy flags reflect the current state only; same-cycle set/clear
   // become visible after the edge.
   assign bus.busy_1   = busy_reg[bus.rd_addr_1];
   assign bus.busy_2   = busy_reg[bus.rd_addr_2];
   assign bus.busy_any = |busy_reg;

endmodule
